// File: rtl/elephant_ise_ctrl.sv
// elephant_ise_ctrl
// Sequencing front-end for the combinational Elephant custom-instruction
// datapath (bsllxor, bup, pstep1). Requests arrive over a valid/ready
// handshake and their operands are registered. The datapath is driven only
// from these registers. Its result is captured and then returned over a
// second valid/ready handshake.
//
// Optional feature macro: ELEPHANT_ISE_ITER_EN
//   defined   : op 11 applies pstep1 req_imm times (ITER state + cnt counter)
//   undefined : op 11 is a single pstep1 through EXEC, imm ignored
//
// Ports
//   clk, rst              : clock, asynchronous active-high reset
//   req_valid/req_ready   : request handshake
//   req_op/rs1/rs2/imm    : request opcode and operands
//   rsp_valid/rsp_ready   : response handshake
//   rsp_rd                : registered result
//   busy                  : high in EXEC/ITER/HOLD
//   ise_rs1/rs2/imm       : datapath operands (registered)
//   ise_op_*              : one-hot datapath selects
//   ise_rd                : combinational datapath result
module elephant_ise_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [4:0]  req_imm,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rd,
  output logic        busy,
  output logic [31:0] ise_rs1,
  output logic [31:0] ise_rs2,
  output logic [4:0]  ise_imm,
  output logic        ise_op_bsllxor,
  output logic        ise_op_bup,
  output logic        ise_op_pstep1,
  input  logic [31:0] ise_rd
);

`ifdef ELEPHANT_ISE_ITER_EN
  typedef enum logic [1:0] {StIdle = 2'd0, StExec = 2'd1, StIter = 2'd2, StHold = 2'd3} state_e;
`else
  typedef enum logic [1:0] {StIdle = 2'd0, StExec = 2'd1, StHold = 2'd3} state_e;
`endif

  state_e      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] opnd2_q, opnd2_d;
  logic [4:0]  imm_q, imm_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] res_q, res_d;
`ifdef ELEPHANT_ISE_ITER_EN
  logic [4:0]  cnt_q, cnt_d;
`endif

  logic accept;

  // Depends only on state and rsp_ready so no path from req_valid exists.
  assign req_ready = (state_q == StIdle) | ((state_q == StHold) & rsp_ready);
  assign accept    = req_valid & req_ready;

  assign ise_rs1 = acc_q;
  assign ise_rs2 = opnd2_q;
  assign ise_imm = imm_q;
  assign rsp_rd  = res_q;

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    opnd2_d        = opnd2_q;
    imm_d          = imm_q;
    op_d           = op_q;
    res_d          = res_q;
`ifdef ELEPHANT_ISE_ITER_EN
    cnt_d          = cnt_q;
`endif
    rsp_valid      = 1'b0;
    busy           = 1'b1;
    ise_op_bsllxor = 1'b0;
    ise_op_bup     = 1'b0;
    ise_op_pstep1  = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
      end
      StExec: begin
        unique case (op_q)
          2'b00:   ise_op_bsllxor = 1'b1;
          2'b01:   ise_op_bup     = 1'b1;
          default: ise_op_pstep1  = 1'b1;  // 10, and 11 when iteration is absent
        endcase
        res_d   = ise_rd;
        state_d = StHold;
      end
`ifdef ELEPHANT_ISE_ITER_EN
      StIter: begin
        ise_op_pstep1 = 1'b1;
        if (cnt_q == 5'd0) begin
          res_d   = acc_q;
          state_d = StHold;
        end else begin
          acc_d = ise_rd;
          cnt_d = cnt_q - 5'd1;
        end
      end
`endif
      StHold: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Accept only happens in IDLE or HOLD; a HOLD accept overrides the IDLE return.
    if (accept) begin
      acc_d   = req_rs1;
      opnd2_d = req_rs2;
      imm_d   = req_imm;
      op_d    = req_op;
`ifdef ELEPHANT_ISE_ITER_EN
      cnt_d   = req_imm;
      state_d = (req_op == 2'b11) ? StIter : StExec;
`else
      state_d = StExec;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= 32'd0;
      opnd2_q <= 32'd0;
      imm_q   <= 5'd0;
      op_q    <= 2'd0;
      res_q   <= 32'd0;
`ifdef ELEPHANT_ISE_ITER_EN
      cnt_q   <= 5'd0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opnd2_q <= opnd2_d;
      imm_q   <= imm_d;
      op_q    <= op_d;
      res_q   <= res_d;
`ifdef ELEPHANT_ISE_ITER_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_elephant_ise_ctrl.sv
// Testbench for elephant_ise_ctrl. Supplies a behavioural datapath:
//   bsllxor = rs1 ^ (rs2 << imm), bup = rs1 << imm, pstep1 = rotate-left by 4.
module tb_elephant_ise_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_rs1, req_rs2;
  logic [4:0]  req_imm;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rd;
  logic        busy;
  logic [31:0] ise_rs1, ise_rs2;
  logic [4:0]  ise_imm;
  logic        ise_op_bsllxor, ise_op_bup, ise_op_pstep1;
  logic [31:0] ise_rd;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  elephant_ise_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_rs1        (req_rs1),
    .req_rs2        (req_rs2),
    .req_imm        (req_imm),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rd         (rsp_rd),
    .busy           (busy),
    .ise_rs1        (ise_rs1),
    .ise_rs2        (ise_rs2),
    .ise_imm        (ise_imm),
    .ise_op_bsllxor (ise_op_bsllxor),
    .ise_op_bup     (ise_op_bup),
    .ise_op_pstep1  (ise_op_pstep1),
    .ise_rd         (ise_rd)
  );

  // Datapath stand-in; output is 0 when no select is active.
  always_comb begin
    ise_rd = 32'd0;
    if (ise_op_bsllxor)     ise_rd = ise_rs1 ^ (ise_rs2 << ise_imm);
    else if (ise_op_bup)    ise_rd = ise_rs1 << ise_imm;
    else if (ise_op_pstep1) ise_rd = {ise_rs1[27:0], ise_rs1[31:28]};
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  imm;
    logic [31:0] exp_rd;
    int          exp_lat;
    logic [2:0]  exp_sel;  // {bsllxor, bup, pstep1} in cycle 1
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue a request from IDLE; returns at the negedge of cycle 1.
  task automatic send(input logic [1:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [4:0] imm);
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_rs1   = rs1;
    req_rs2   = rs2;
    req_imm   = imm;
    #1;
    chk("req_ready_idle", {95'd0, req_ready}, 96'd1);
    @(posedge clk);
    @(negedge clk);
    // Scramble request fields; the op in flight must not see them.
    req_valid = 1'b0;
    req_op    = 2'b10;
    req_rs1   = 32'hDEADBEEF;
    req_rs2   = 32'hCAFEF00D;
    req_imm   = 5'd17;
  endtask

  // Current negedge counts as cycle 1; returns latency in cycles.
  task automatic wait_rsp(output int lat);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Consume the held response and confirm return to IDLE.
  task automatic release_rsp();
    rsp_ready = 1'b1;
    #1;
    chk("req_ready_hold_rdy", {95'd0, req_ready}, 96'd1);
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("idle_after_rsp", {94'd0, rsp_valid, busy}, 96'd0);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, {ise_rs1, ise_rs2, ise_imm, ise_op_bsllxor, ise_op_bup, ise_op_pstep1,
               req_ready, rsp_valid, busy, 12'd0}, {72'd0, 3'b100, 12'd0} >> 0);
    chk({name, "_rd"}, {64'd0, rsp_rd}, 96'd0);
  endtask

  initial begin
    int lat;
    logic [2:0] sel;
    logic seen;

    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [2:0] sel;
    logic seen;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_rs1   = 32'd0;
    req_rs2   = 32'd0;
    req_imm   = 5'd0;
    rsp_ready = 1'b0;

    vecs[0] = '{2'b00, 32'h00000000, 32'h000000FF, 5'd8, 32'h0000FF00, 2, 3'b100};
    vecs[1] = '{2'b01, 32'h00000001, 32'h00000000, 5'd5, 32'h00000020, 2, 3'b010};
    vecs[2] = '{2'b10, 32'h12345678, 32'h00000000, 5'd0, 32'h23456781, 2, 3'b001};
    vecs[3] = '{2'b00, 32'hA5A5A5A5, 32'h0000000F, 5'd4, 32'hA5A5A555, 2, 3'b100};
    vecs[4] = '{2'b01, 32'h80000001, 32'hFFFFFFFF, 5'd1, 32'h00000002, 2, 3'b010};
`ifdef ELEPHANT_ISE_ITER_EN
    vecs[5] = '{2'b11, 32'h12345678, 32'h00000000, 5'd0, 32'h12345678, 2, 3'b001};
    vecs[6] = '{2'b11, 32'h12345678, 32'h00000000, 5'd3, 32'h45678123, 5, 3'b001};
    vecs[7] = '{2'b11, 32'h12345678, 32'h00000000, 5'd1, 32'h23456781, 3, 3'b001};
`else
    vecs[5] = '{2'b11, 32'h12345678, 32'h00000000, 5'd0, 32'h23456781, 2, 3'b001};
    vecs[6] = '{2'b11, 32'h12345678, 32'h00000000, 5'd3, 32'h23456781, 2, 3'b001};
    vecs[7] = '{2'b11, 32'h12345678, 32'h00000000, 5'd1, 32'h23456781, 2, 3'b001};
`endif

    // Reset values
    @(negedge clk);
    @(negedge clk);
    chk_reset_outputs("reset_state");
    rst = 1'b0;

    // Table-driven single operations
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      sel = {ise_op_bsllxor, ise_op_bup, ise_op_pstep1};
      chk($sformatf("v%0d_sel_c1", i), {93'd0, sel}, {93'd0, vecs[i].exp_sel});
      chk($sformatf("v%0d_busy_c1", i), {95'd0, busy}, 96'd1);
      wait_rsp(lat);
      chk($sformatf("v%0d_latency", i), 96'(lat), 96'(vecs[i].exp_lat));
      chk($sformatf("v%0d_rd", i), {64'd0, rsp_rd}, {64'd0, vecs[i].exp_rd});
      chk($sformatf("v%0d_sel_hold", i),
          {93'd0, ise_op_bsllxor, ise_op_bup, ise_op_pstep1}, 96'd0);
      release_rsp();
    end

    // Backpressure: response held for 4 cycles
    send(2'b00, 32'h00000000, 32'h000000FF, 5'd8);
    wait_rsp(lat);
    chk("bp_latency", 96'(lat), 96'd2);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", k), {rsp_rd, 29'd0, req_ready, busy, rsp_valid},
          {32'h0000FF00, 29'd0, 3'b011});
    end
    release_rsp();

    // Back-to-back: accept in HOLD while the response is consumed
    send(2'b01, 32'h00000003, 32'h00000000, 5'd2);
    wait_rsp(lat);
    chk("b2b_first_rd", {64'd0, rsp_rd}, {64'd0, 32'h0000000C});
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_rs1   = 32'h00000000;
    req_rs2   = 32'h00000001;
    req_imm   = 5'd31;
    #1;
    chk("b2b_req_ready", {95'd0, req_ready}, 96'd1);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("b2b_exec", {93'd0, rsp_valid, busy, ise_op_bsllxor}, {93'd0, 3'b011});
    @(negedge clk);
    chk("b2b_second", {rsp_valid, 63'd0, rsp_rd}, {1'b1, 63'd0, 32'h80000000});
    release_rsp();

    // Asynchronous reset mid-operation (cycle 6)
    send(2'b11, 32'h12345678, 32'h00000000, 5'd20);
    for (int k = 0; k < 5; k++) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_reset");
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    rsp_ready = 1'b0;
    chk("no_rsp_after_reset", {95'd0, seen}, 96'd0);

    send(2'b10, 32'h0000000F, 32'h00000000, 5'd0);
    wait_rsp(lat);
    chk("post_reset_lat", 96'(lat), 96'd2);
    chk("post_reset_rd", {64'd0, rsp_rd}, {64'd0, 32'h000000F0});
    release_rsp();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
